alu_muldiv_seq: RTL



---
 rtl/alu_muldiv_seq_if.sv | 26 ++
 rtl/alu_muldiv_seq.sv | 143 ++++++++++++++
 2 files changed

// File: rtl/alu_muldiv_seq_if.sv
// Request/response bundle for the iterative multiply/divide unit.
interface alu_muldiv_seq_if #(
    parameter int unsigned XLEN = 32
);
    logic            in_valid;
    logic            in_ready;
    logic [2:0]      op;
    logic [XLEN-1:0] rs1;
    logic [XLEN-1:0] rs2;
    logic            out_valid;
    logic            out_ready;
    logic [XLEN-1:0] rd;
    logic            busy;

    // Requester / result consumer side
    modport master (
        output in_valid, op, rs1, rs2, out_ready,
        input  in_ready, out_valid, rd, busy
    );

    // Execution unit side
    modport slave (
        input  in_valid, op, rs1, rs2, out_ready,
        output in_ready, out_valid, rd, busy
    );
endinterface

// File: rtl/alu_muldiv_seq.sv
// Iterative RISC-V M-extension unit: shift-add multiply, restoring divide,
// both on operand magnitudes with a sign fix folded into the last iteration.
module alu_muldiv_seq #(
    parameter int unsigned XLEN = 32
) (
    input  logic               clk,
    input  logic               rst,
    alu_muldiv_seq_if.slave    bus
);
    localparam int unsigned CW = $clog2(XLEN) + 1;
    localparam int unsigned DW = 2 * XLEN;

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t          state_q, state_d;
    logic [CW-1:0]   cnt_q;
    logic [2:0]      op_q;
    logic [DW-1:0]   a_q;      // multiplicand (shifting left) / dividend-quotient shifter
    logic [XLEN-1:0] b_q;      // multiplier (shifting right) / divisor
    logic [DW-1:0]   acc_q;    // product accumulator / partial remainder
    logic            neg_q;    // negate product or quotient at the end
    logic            rneg_q;   // negate remainder at the end
    logic [XLEN-1:0] rd_q;

    logic            accept_c;
    logic            is_div_c, s1_signed_c, s2_signed_c, neg1_c, neg2_c;
    logic [XLEN-1:0] mag1_c, mag2_c;
    logic            div_zero_c, div_ovf_c, fast_c, last_c;
    logic [XLEN-1:0] fast_res_c;
    logic [XLEN:0]   trial_c, diff_c, rem_n_c;
    logic            qbit_c;
    logic [DW-1:0]   a_n_c, acc_n_c, prod_c;
    logic [XLEN-1:0] b_n_c, quot_c, rem_c, result_c;

    assign bus.in_ready  = (state_q == IDLE) && !rst;
    assign bus.out_valid = (state_q == DONE);
    assign bus.busy      = (state_q != IDLE);
    assign bus.rd        = rd_q;

    assign accept_c = bus.in_valid && bus.in_ready;
    assign last_c   = (cnt_q == CW'(XLEN - 1));

    // Operand decode, magnitudes and the divide corner cases resolved at accept
    always_comb begin
        is_div_c    = bus.op[2];
        s1_signed_c = is_div_c ? !bus.op[0] : (bus.op[1:0] == 2'b01 || bus.op[1:0] == 2'b10);
        s2_signed_c = is_div_c ? !bus.op[0] : (bus.op[1:0] == 2'b01);
        neg1_c      = s1_signed_c && bus.rs1[XLEN-1];
        neg2_c      = s2_signed_c && bus.rs2[XLEN-1];
        mag1_c      = neg1_c ? (XLEN'(0) - bus.rs1) : bus.rs1;
        mag2_c      = neg2_c ? (XLEN'(0) - bus.rs2) : bus.rs2;
        div_zero_c  = is_div_c && (bus.rs2 == '0);
        div_ovf_c   = is_div_c && !bus.op[0]
                      && (bus.rs1 == {1'b1, {(XLEN-1){1'b0}}}) && (bus.rs2 == '1);
        fast_c      = div_zero_c || div_ovf_c;
        fast_res_c  = '0;
        if (div_zero_c) begin
            fast_res_c = bus.op[1] ? bus.rs1 : '1;
        end else if (div_ovf_c) begin
            fast_res_c = bus.op[1] ? '0 : bus.rs1;
        end
    end

    // One iteration of multiply or divide, plus the signed result of that step
    always_comb begin
        trial_c = {acc_q[XLEN-1:0], a_q[XLEN-1]};
        diff_c  = trial_c - {1'b0, b_q};
        qbit_c  = !diff_c[XLEN];
        rem_n_c = qbit_c ? diff_c : trial_c;
        if (op_q[2]) begin
            acc_n_c = DW'(rem_n_c);
            a_n_c   = {XLEN'(0), a_q[XLEN-2:0], qbit_c};
            b_n_c   = b_q;
        end else begin
            acc_n_c = b_q[0] ? (acc_q + a_q) : acc_q;
            a_n_c   = {a_q[DW-2:0], 1'b0};
            b_n_c   = {1'b0, b_q[XLEN-1:1]};
        end
        prod_c = neg_q  ? (DW'(0) - acc_n_c) : acc_n_c;
        quot_c = neg_q  ? (XLEN'(0) - a_n_c[XLEN-1:0]) : a_n_c[XLEN-1:0];
        rem_c  = rneg_q ? (XLEN'(0) - acc_n_c[XLEN-1:0]) : acc_n_c[XLEN-1:0];
        case (op_q)
            3'b000:         result_c = prod_c[XLEN-1:0];
            3'b100, 3'b101: result_c = quot_c;
            3'b110, 3'b111: result_c = rem_c;
            default:        result_c = prod_c[DW-1:XLEN];
        endcase
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: if (accept_c) state_d = fast_c ? DONE : RUN;
            RUN:  if (last_c) state_d = DONE;
            DONE: if (bus.out_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // State register
    always_ff @(posedge clk) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    // Operand capture, iteration datapath and result register
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q  <= '0;
            op_q   <= '0;
            a_q    <= '0;
            b_q    <= '0;
            acc_q  <= '0;
            neg_q  <= 1'b0;
            rneg_q <= 1'b0;
            rd_q   <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (accept_c) begin
                        op_q   <= bus.op;
                        cnt_q  <= '0;
                        a_q    <= {XLEN'(0), mag1_c};
                        b_q    <= mag2_c;
                        acc_q  <= '0;
                        neg_q  <= neg1_c ^ neg2_c;
                        rneg_q <= neg1_c;
                        if (fast_c) rd_q <= fast_res_c;
                    end
                end
                RUN: begin
                    a_q   <= a_n_c;
                    b_q   <= b_n_c;
                    acc_q <= acc_n_c;
                    cnt_q <= cnt_q + CW'(1);
                    if (last_c) rd_q <= result_c;
                end
                default: ;
            endcase
        end
    end
endmodule
